mod_arbiter: RTL

//   Shares one combinational Modulo datapath (16b P,Q -> 32b remainder, divZero) between
//   N_REQ requesters. Round-robin grant, operand registering, fixed-latency wait, then one

---
 rtl/mod_arbiter_pkg.sv | 21 ++
 rtl/mod_arbiter_rr_pick.sv | 35 +++
 rtl/mod_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mod_arbiter_pkg.sv
// Shared definitions for the modulo-datapath arbiter: default widths,
// FSM state encoding and a width helper.
package mod_arbiter_pkg;

  localparam int unsigned DEF_N_REQ     = 2;
  localparam int unsigned DEF_WIDTH_IN  = 16;
  localparam int unsigned DEF_WIDTH_OUT = 32;
  localparam int unsigned DEF_MOD_LAT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req       : pending request vector
//   ptr       : highest-priority requester index this cycle
//   grant     : one-hot grant of the first set bit scanning ptr, ptr+1, ... mod N_REQ
//   idx       : binary index of the granted requester
//   any_valid : at least one request pending
module mod_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any_valid
);

  // Walk the requesters in rotated order; first hit wins.
  always_comb begin
    int unsigned k;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    k         = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      k = (32'(ptr) + off) % N_REQ;
      if (!any_valid && req[k]) begin
        any_valid = 1'b1;
        grant[k]  = 1'b1;
        idx       = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// Shares one combinational modulo datapath between N_REQ requesters.
// Round-robin grant in IDLE, operands registered onto mod_p/mod_q, a fixed
// MOD_LAT-cycle wait, then one tagged response on a valid/ready channel.
//   req_valid/req_ready/req_p/req_q : per-requester operand channels (packed)
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_div_zero : response channel
//   mod_p/mod_q -> external Modulo inputs, mod_result/mod_div_zero <- outputs
module mod_arbiter
  import mod_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ     = DEF_N_REQ,
  parameter  int unsigned WIDTH_IN  = DEF_WIDTH_IN,
  parameter  int unsigned WIDTH_OUT = DEF_WIDTH_OUT,
  parameter  int unsigned MOD_LAT   = DEF_MOD_LAT,
  localparam int unsigned ID_W      = min1_clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*WIDTH_IN-1:0] req_p,
  input  logic [N_REQ*WIDTH_IN-1:0] req_q,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WIDTH_OUT-1:0]      rsp_result,
  output logic                      rsp_div_zero,
  output logic [WIDTH_IN-1:0]       mod_p,
  output logic [WIDTH_IN-1:0]       mod_q,
  input  logic [WIDTH_OUT-1:0]      mod_result,
  input  logic                      mod_div_zero
);

  localparam int unsigned CNT_W = min1_clog2(MOD_LAT);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bubble_q, bubble_d;
  logic [WIDTH_IN-1:0]  mod_p_q, mod_p_d;
  logic [WIDTH_IN-1:0]  mod_q_q, mod_q_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [WIDTH_OUT-1:0] rsp_result_q, rsp_result_d;
  logic                 rsp_div_zero_q, rsp_div_zero_d;

  logic [N_REQ-1:0]     pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [WIDTH_IN-1:0]  sel_p, sel_q;

  mod_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Operands of the candidate winner.
  assign sel_p = req_p[WIDTH_IN*pick_idx +: WIDTH_IN];
  assign sel_q = req_q[WIDTH_IN*pick_idx +: WIDTH_IN];

  // Next-state and grant logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    bubble_d       = 1'b0;
    mod_p_d        = mod_p_q;
    mod_q_d        = mod_q_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_div_zero_d = rsp_div_zero_q;
    req_ready      = '0;

    unique case (state_q)
      ST_IDLE: begin
        // The first IDLE cycle after a response handshake is a bubble.
        if (!bubble_q && pick_any) begin
          req_ready = pick_grant;
          mod_p_d   = sel_p;
          mod_q_d   = sel_q;
          rsp_id_d  = pick_idx;
          rr_ptr_d  = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          if (sel_q == '0) begin
            // Divide-by-zero needs no datapath time.
            state_d        = ST_RESP;
            rsp_valid_d    = 1'b1;
            rsp_result_d   = '0;
            rsp_div_zero_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(MOD_LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d        = ST_RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = mod_result;
          rsp_div_zero_d = mod_div_zero;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          bubble_d    = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      bubble_q       <= 1'b0;
      mod_p_q        <= '0;
      mod_q_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_div_zero_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      bubble_q       <= bubble_d;
      mod_p_q        <= mod_p_d;
      mod_q_q        <= mod_q_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_div_zero_q <= rsp_div_zero_d;
    end
  end

  assign mod_p        = mod_p_q;
  assign mod_q        = mod_q_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_div_zero = rsp_div_zero_q;

endmodule
